// File: rtl/chaining_record_table_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chaining_record_table_pkg
// Purpose  : Shared types and widths for the chaining record table and the
//            downstream per-record write-hazard checker.
// Contents : ELEM_MASK_W, INST_IDX_W, VREG_W, ELEM_IDX_W, record_t
// Revision : 1.0 - initial release
// ============================================================================
package chaining_record_table_pkg;

  localparam int ELEM_MASK_W = 512;
  localparam int INST_IDX_W  = 3;
  localparam int VREG_W      = 5;
  // Element index is {vreg[2:0], offset[5:0]}
  localparam int ELEM_IDX_W  = $clog2(ELEM_MASK_W);

  typedef struct packed {
    logic                   vd_valid;
    logic [VREG_W-1:0]      vd_bits;
    logic                   vs1_valid;
    logic [VREG_W-1:0]      vs1_bits;
    logic [VREG_W-1:0]      vs2;
    logic [INST_IDX_W-1:0]  instIndex;
    logic                   gather;
    logic                   gather16;
    logic                   onlyRead;
    logic [ELEM_MASK_W-1:0] elementMask;
  } record_t;

endpackage
`default_nettype wire

// File: rtl/chaining_record_slot.sv
`default_nettype none
// ============================================================================
// Module   : chaining_record_slot
// Purpose  : Storage for one in-flight instruction record: valid flag,
//            footprint fields, element-progress mask and tag matching.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            i_alloc_we        - write i_alloc_rec into this slot (mask pre-cleared)
//            i_upd_*           - set one element-mask bit on tag match
//            i_ret_*           - clear valid on tag match
//            i_dup_tag         - tag probed for the duplicate-allocation check
//            o_valid, o_rec    - registered slot contents
//            o_dup_hit         - slot valid and holds i_dup_tag
//            o_ret_hit         - retire is effective on this slot this cycle
// Revision : 1.0 - initial release
// ============================================================================
module chaining_record_slot
  import chaining_record_table_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_alloc_we,
  input  record_t               i_alloc_rec,
  input  logic                  i_upd_valid,
  input  logic [INST_IDX_W-1:0] i_upd_tag,
  input  logic [ELEM_IDX_W-1:0] i_upd_index,
  input  logic                  i_ret_valid,
  input  logic [INST_IDX_W-1:0] i_ret_tag,
  input  logic [INST_IDX_W-1:0] i_dup_tag,
  output logic                  o_valid,
  output record_t               o_rec,
  output logic                  o_dup_hit,
  output logic                  o_ret_hit
);

  logic    r_valid;
  record_t r_rec;
  logic    w_upd_hit;
  logic    w_ret_hit;

  // Matches only consider a valid record, so an alloc into this (free) slot
  // can never coincide with an update or retire hit on it.
  assign w_upd_hit = r_valid & i_upd_valid & (r_rec.instIndex == i_upd_tag);
  assign w_ret_hit = r_valid & i_ret_valid & (r_rec.instIndex == i_ret_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_rec   <= '0;
    end else if (i_alloc_we) begin
      r_valid <= 1'b1;
      r_rec   <= i_alloc_rec;
    end else if (w_ret_hit) begin
      // Retire beats a same-cycle update; fields are left stale.
      r_valid <= 1'b0;
    end else if (w_upd_hit) begin
      r_rec.elementMask[i_upd_index] <= 1'b1;
    end
  end

  assign o_valid   = r_valid;
  assign o_rec     = r_rec;
  assign o_dup_hit = r_valid & (r_rec.instIndex == i_dup_tag);
  assign o_ret_hit = w_ret_hit;

endmodule
`default_nettype wire

// File: rtl/chaining_record_table.sv
`default_nettype none
// ============================================================================
// Module   : chaining_record_table
// Purpose  : Table of in-flight instruction footprint records feeding the
//            lane write-hazard checker. Allocates on issue (lowest free
//            slot), marks element progress, frees on retire.
// Ports    : clock, reset                - clock, synchronous active-high reset
//            alloc_*                     - issue handshake and record fields
//            update_*                    - mark one element complete by tag
//            retire_*                    - free a record by tag
//            rec_*                       - per-slot registered contents, flattened
//            occupancy                   - registered count of valid slots
//            dup_error                   - sticky duplicate-tag allocation flag
// Revision : 1.0 - initial release
// ============================================================================
module chaining_record_table #(
  parameter int NUM_RECORDS = 4,
  // Must match the package widths; the record struct is built from them.
  parameter int ELEM_MASK_W = chaining_record_table_pkg::ELEM_MASK_W,
  parameter int INST_IDX_W  = chaining_record_table_pkg::INST_IDX_W
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 alloc_valid,
  output logic                                 alloc_ready,
  input  logic                                 alloc_vd_valid,
  input  logic [4:0]                           alloc_vd_bits,
  input  logic                                 alloc_vs1_valid,
  input  logic [4:0]                           alloc_vs1_bits,
  input  logic [4:0]                           alloc_vs2,
  input  logic [INST_IDX_W-1:0]                alloc_instIndex,
  input  logic                                 alloc_gather,
  input  logic                                 alloc_gather16,
  input  logic                                 alloc_onlyRead,
  input  logic                                 update_valid,
  input  logic [INST_IDX_W-1:0]                update_instIndex,
  input  logic [8:0]                           update_index,
  input  logic                                 retire_valid,
  input  logic [INST_IDX_W-1:0]                retire_instIndex,
  output logic [NUM_RECORDS-1:0]               rec_valid,
  output logic [NUM_RECORDS-1:0]               rec_vd_valid,
  output logic [NUM_RECORDS-1:0]               rec_vs1_valid,
  output logic [NUM_RECORDS-1:0]               rec_gather,
  output logic [NUM_RECORDS-1:0]               rec_gather16,
  output logic [NUM_RECORDS-1:0]               rec_onlyRead,
  output logic [5*NUM_RECORDS-1:0]             rec_vd_bits,
  output logic [5*NUM_RECORDS-1:0]             rec_vs1_bits,
  output logic [5*NUM_RECORDS-1:0]             rec_vs2,
  output logic [INST_IDX_W*NUM_RECORDS-1:0]    rec_instIndex,
  output logic [ELEM_MASK_W*NUM_RECORDS-1:0]   rec_elementMask,
  output logic [$clog2(NUM_RECORDS+1)-1:0]     occupancy,
  output logic                                 dup_error
);

  import chaining_record_table_pkg::record_t;

  localparam int OCC_W = $clog2(NUM_RECORDS+1);

  logic [NUM_RECORDS-1:0] w_valid;
  logic [NUM_RECORDS-1:0] w_free;
  logic [NUM_RECORDS-1:0] w_sel_oh;
  logic [NUM_RECORDS-1:0] w_dup_hit;
  logic [NUM_RECORDS-1:0] w_ret_hit;
  record_t                w_rec [NUM_RECORDS];
  record_t                w_alloc_rec;
  logic                   w_fire;
  logic                   w_dup;
  logic                   w_accept;
  logic                   w_retire_any;
  logic [OCC_W-1:0]       r_occupancy;
  logic                   r_dup_error;

  assign w_free      = ~w_valid;
  assign alloc_ready = |w_free;

  // Lowest-numbered free slot, one-hot. Scanning downward lets the lowest
  // free index overwrite any higher one.
  always_comb begin
    w_sel_oh = '0;
    for (int i = NUM_RECORDS - 1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
      end
    end
  end

  // Duplicate check uses pre-edge valid state, so a same-cycle retire of the
  // same tag still counts as a duplicate.
  assign w_fire       = alloc_valid & alloc_ready;
  assign w_dup        = |w_dup_hit;
  assign w_accept     = w_fire & ~w_dup;
  assign w_retire_any = |w_ret_hit;

  always_comb begin
    w_alloc_rec             = '0;
    w_alloc_rec.vd_valid    = alloc_vd_valid;
    w_alloc_rec.vd_bits     = alloc_vd_bits;
    w_alloc_rec.vs1_valid   = alloc_vs1_valid;
    w_alloc_rec.vs1_bits    = alloc_vs1_bits;
    w_alloc_rec.vs2         = alloc_vs2;
    w_alloc_rec.instIndex   = alloc_instIndex;
    w_alloc_rec.gather      = alloc_gather;
    w_alloc_rec.gather16    = alloc_gather16;
    w_alloc_rec.onlyRead    = alloc_onlyRead;
  end

  generate
    for (genvar i = 0; i < NUM_RECORDS; i++) begin : g_slot
      chaining_record_slot u_slot (
        .clk         (clock),
        .rst         (reset),
        .i_alloc_we  (w_accept & w_sel_oh[i]),
        .i_alloc_rec (w_alloc_rec),
        .i_upd_valid (update_valid),
        .i_upd_tag   (update_instIndex),
        .i_upd_index (update_index),
        .i_ret_valid (retire_valid),
        .i_ret_tag   (retire_instIndex),
        .i_dup_tag   (alloc_instIndex),
        .o_valid     (w_valid[i]),
        .o_rec       (w_rec[i]),
        .o_dup_hit   (w_dup_hit[i]),
        .o_ret_hit   (w_ret_hit[i])
      );

      assign rec_valid[i]                                  = w_valid[i];
      assign rec_vd_valid[i]                               = w_rec[i].vd_valid;
      assign rec_vs1_valid[i]                              = w_rec[i].vs1_valid;
      assign rec_gather[i]                                 = w_rec[i].gather;
      assign rec_gather16[i]                               = w_rec[i].gather16;
      assign rec_onlyRead[i]                               = w_rec[i].onlyRead;
      assign rec_vd_bits[5*i +: 5]                         = w_rec[i].vd_bits;
      assign rec_vs1_bits[5*i +: 5]                        = w_rec[i].vs1_bits;
      assign rec_vs2[5*i +: 5]                             = w_rec[i].vs2;
      assign rec_instIndex[INST_IDX_W*i +: INST_IDX_W]     = w_rec[i].instIndex;
      assign rec_elementMask[ELEM_MASK_W*i +: ELEM_MASK_W] = w_rec[i].elementMask;
    end
  endgenerate

  // Tags of valid records are unique, so at most one retire hit per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_occupancy <= '0;
      r_dup_error <= 1'b0;
    end else begin
      if (w_fire & w_dup) begin
        r_dup_error <= 1'b1;
      end
      case ({w_accept, w_retire_any})
        2'b10:   r_occupancy <= r_occupancy + OCC_W'(1);
        2'b01:   r_occupancy <= r_occupancy - OCC_W'(1);
        default: r_occupancy <= r_occupancy;
      endcase
    end
  end

  assign occupancy = r_occupancy;
  assign dup_error = r_dup_error;

endmodule
`default_nettype wire

// File: tb/tb_chaining_record_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_chaining_record_table
// Purpose  : Self-checking bench for chaining_record_table. Expected slot
//            contents are queued when an allocation or update is driven and
//            compared once the record becomes visible.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chaining_record_table;

  localparam int NR = 4;
  localparam int MW = 512;
  localparam int TW = 3;
  localparam int OW = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            alloc_valid, alloc_ready;
  logic            alloc_vd_valid, alloc_vs1_valid;
  logic [4:0]      alloc_vd_bits, alloc_vs1_bits, alloc_vs2;
  logic [TW-1:0]   alloc_instIndex;
  logic            alloc_gather, alloc_gather16, alloc_onlyRead;
  logic            update_valid;
  logic [TW-1:0]   update_instIndex;
  logic [8:0]      update_index;
  logic            retire_valid;
  logic [TW-1:0]   retire_instIndex;
  logic [NR-1:0]   rec_valid, rec_vd_valid, rec_vs1_valid;
  logic [NR-1:0]   rec_gather, rec_gather16, rec_onlyRead;
  logic [5*NR-1:0] rec_vd_bits, rec_vs1_bits, rec_vs2;
  logic [TW*NR-1:0] rec_instIndex;
  logic [MW*NR-1:0] rec_elementMask;
  logic [OW-1:0]   occupancy;
  logic            dup_error;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         slot;
    logic [2:0] tag;
    logic [4:0] vd;
    logic [4:0] vs2;
  } exp_t;

  exp_t          sb[$];
  logic [MW-1:0] mask_q[$];

  chaining_record_table #(.NUM_RECORDS(NR), .ELEM_MASK_W(MW), .INST_IDX_W(TW)) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_vd_valid(alloc_vd_valid), .alloc_vd_bits(alloc_vd_bits),
    .alloc_vs1_valid(alloc_vs1_valid), .alloc_vs1_bits(alloc_vs1_bits),
    .alloc_vs2(alloc_vs2), .alloc_instIndex(alloc_instIndex),
    .alloc_gather(alloc_gather), .alloc_gather16(alloc_gather16),
    .alloc_onlyRead(alloc_onlyRead),
    .update_valid(update_valid), .update_instIndex(update_instIndex),
    .update_index(update_index),
    .retire_valid(retire_valid), .retire_instIndex(retire_instIndex),
    .rec_valid(rec_valid), .rec_vd_valid(rec_vd_valid),
    .rec_vs1_valid(rec_vs1_valid), .rec_gather(rec_gather),
    .rec_gather16(rec_gather16), .rec_onlyRead(rec_onlyRead),
    .rec_vd_bits(rec_vd_bits), .rec_vs1_bits(rec_vs1_bits), .rec_vs2(rec_vs2),
    .rec_instIndex(rec_instIndex), .rec_elementMask(rec_elementMask),
    .occupancy(occupancy), .dup_error(dup_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; alloc_vd_valid = 0; alloc_vd_bits = 0; alloc_vs1_valid = 0;
    alloc_vs1_bits = 0; alloc_vs2 = 0; alloc_instIndex = 0; alloc_gather = 0;
    alloc_gather16 = 0; alloc_onlyRead = 0; update_valid = 0; update_instIndex = 0;
    update_index = 0; retire_valid = 0; retire_instIndex = 0;
  endtask

  task automatic drive_alloc(input logic [2:0] tag, input logic [4:0] vd);
    alloc_valid = 1; alloc_vd_valid = 1; alloc_vd_bits = vd;
    alloc_vs1_valid = 1; alloc_vs1_bits = vd ^ 5'h1f; alloc_vs2 = vd + 5'd2;
    alloc_instIndex = tag; alloc_gather = 0; alloc_gather16 = 0; alloc_onlyRead = 0;
  endtask

  task automatic push_exp(input int slot, input logic [2:0] tag, input logic [4:0] vd);
    exp_t e;
    e.slot = slot; e.tag = tag; e.vd = vd; e.vs2 = vd + 5'd2;
    sb.push_back(e);
  endtask

  task automatic pulse_reset();
    reset = 1; idle_inputs(); tick(); reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs(); tick(); tick(); reset = 0;
    n_checks++;
    if ({rec_valid, occupancy, dup_error, alloc_ready} !== {4'b0000, 3'd0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_state: got valid=%b occ=%0d dup=%b ready=%b required 0000/0/0/1",
               rec_valid, occupancy, dup_error, alloc_ready);
    end
    n_checks++;
    if ((rec_elementMask !== '0) || (rec_instIndex !== '0) || (rec_vd_bits !== '0)) begin
      n_errors++;
      $display("FAIL reset_fields: masks/tags/vd not zero (tags=%h vd=%h)", rec_instIndex, rec_vd_bits);
    end
  endtask

  task automatic test_alloc_basic();
    drive_alloc(3'd3, 5'd8); push_exp(0, 3'd3, 5'd8);
    tick(); idle_inputs();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (rec_valid[e.slot] !== 1'b1 || rec_instIndex[3*e.slot +: 3] !== e.tag ||
          rec_vd_bits[5*e.slot +: 5] !== e.vd || rec_vs2[5*e.slot +: 5] !== e.vs2 ||
          rec_vd_valid[e.slot] !== 1'b1 || rec_elementMask[MW*e.slot +: MW] !== '0) begin
        n_errors++;
        $display("FAIL alloc_basic slot%0d: got v=%b tag=%0d vd=%0d vs2=%0d required v=1 tag=%0d vd=%0d vs2=%0d mask=0",
                 e.slot, rec_valid[e.slot], rec_instIndex[3*e.slot +: 3], rec_vd_bits[5*e.slot +: 5],
                 rec_vs2[5*e.slot +: 5], e.tag, e.vd, e.vs2);
      end
    end
    n_checks++;
    if (rec_valid !== 4'b0001 || occupancy !== 3'd1) begin
      n_errors++;
      $display("FAIL alloc_basic_state: got valid=%b occ=%0d required 0001/1", rec_valid, occupancy);
    end
  endtask

  task automatic test_fill_and_retire();
    pulse_reset();
    for (int t = 0; t < 4; t++) begin
      drive_alloc(3'(t), 5'(10 + t)); push_exp(t, 3'(t), 5'(10 + t));
      tick();
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        if (rec_valid[e.slot] !== 1'b1 || rec_instIndex[3*e.slot +: 3] !== e.tag ||
            rec_vd_bits[5*e.slot +: 5] !== e.vd) begin
          n_errors++;
          $display("FAIL fill slot%0d: got v=%b tag=%0d vd=%0d required v=1 tag=%0d vd=%0d",
                   e.slot, rec_valid[e.slot], rec_instIndex[3*e.slot +: 3],
                   rec_vd_bits[5*e.slot +: 5], e.tag, e.vd);
        end
      end
    end
    idle_inputs();
    n_checks++;
    if (alloc_ready !== 1'b0 || occupancy !== 3'd4) begin
      n_errors++;
      $display("FAIL full_state: got ready=%b occ=%0d required 0/4", alloc_ready, occupancy);
    end
    drive_alloc(3'd5, 5'd1); tick(); idle_inputs();
    n_checks++;
    if (rec_valid !== 4'b1111 || occupancy !== 3'd4 || dup_error !== 1'b0 ||
        rec_instIndex !== {3'd3, 3'd2, 3'd1, 3'd0}) begin
      n_errors++;
      $display("FAIL alloc_when_full: got valid=%b occ=%0d dup=%b tags=%h required 1111/4/0/tags 3,2,1,0",
               rec_valid, occupancy, dup_error, rec_instIndex);
    end
    retire_valid = 1; retire_instIndex = 3'd1; tick(); idle_inputs();
    n_checks++;
    if (alloc_ready !== 1'b1 || rec_valid !== 4'b1101 || occupancy !== 3'd3) begin
      n_errors++;
      $display("FAIL retire_one: got ready=%b valid=%b occ=%0d required 1/1101/3",
               alloc_ready, rec_valid, occupancy);
    end
    drive_alloc(3'd6, 5'd20); push_exp(1, 3'd6, 5'd20); tick(); idle_inputs();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (rec_valid[e.slot] !== 1'b1 || rec_instIndex[3*e.slot +: 3] !== e.tag ||
          rec_vd_bits[5*e.slot +: 5] !== e.vd || occupancy !== 3'd4) begin
        n_errors++;
        $display("FAIL refill slot%0d: got v=%b tag=%0d vd=%0d occ=%0d required v=1 tag=%0d vd=%0d occ=4",
                 e.slot, rec_valid[e.slot], rec_instIndex[3*e.slot +: 3],
                 rec_vd_bits[5*e.slot +: 5], occupancy, e.tag, e.vd);
      end
    end
  endtask

  // Table holds tags 0,6,2,3 in slots 0..3 on entry.
  task automatic test_update();
    logic [MW-1:0] m;
    int idx [4] = '{0, 63, 511, 63};
    m = '0;
    for (int k = 0; k < 5; k++) begin
      update_valid = 1;
      if (k < 4) begin
        update_instIndex = 3'd2; update_index = 9'(idx[k]); m[idx[k]] = 1'b1;
      end else begin
        update_instIndex = 3'd5; update_index = 9'd100;
      end
      mask_q.push_back(m);
      tick();
      while (mask_q.size() > 0) begin
        logic [MW-1:0] em;
        em = mask_q.pop_front();
        n_checks++;
        if (rec_elementMask[MW*2 +: MW] !== em) begin
          n_errors++;
          $display("FAIL update_mask step%0d: got %h required %h", k, rec_elementMask[MW*2 +: MW], em);
        end
      end
    end
    idle_inputs();
    n_checks++;
    if (rec_elementMask[0 +: MW] !== '0 || rec_elementMask[MW +: MW] !== '0 ||
        rec_elementMask[3*MW +: MW] !== '0) begin
      n_errors++;
      $display("FAIL update_other_slots: got nonzero mask on slot 0/1/3, required all zero");
    end
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    for (int t = 0; t < 3; t++) begin
      drive_alloc(3'(t), 5'(t + 1)); tick();
    end
    idle_inputs();
    retire_valid = 1; retire_instIndex = 3'd0;
    update_valid = 1; update_instIndex = 3'd0; update_index = 9'd7;
    drive_alloc(3'd4, 5'd25); push_exp(3, 3'd4, 5'd25);
    tick(); idle_inputs();
    n_checks++;
    if (rec_valid !== 4'b1110 || occupancy !== 3'd3) begin
      n_errors++;
      $display("FAIL simul_state: got valid=%b occ=%0d required 1110/3", rec_valid, occupancy);
    end
    drive_alloc(3'd5, 5'd30); push_exp(0, 3'd5, 5'd30);
    update_valid = 1; update_instIndex = 3'd5; update_index = 9'd9;
    while (sb.size() > 1) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (rec_valid[e.slot] !== 1'b1 || rec_instIndex[3*e.slot +: 3] !== e.tag ||
          rec_vd_bits[5*e.slot +: 5] !== e.vd) begin
        n_errors++;
        $display("FAIL simul_alloc slot%0d: got v=%b tag=%0d vd=%0d required v=1 tag=%0d vd=%0d",
                 e.slot, rec_valid[e.slot], rec_instIndex[3*e.slot +: 3],
                 rec_vd_bits[5*e.slot +: 5], e.tag, e.vd);
      end
    end
    tick(); idle_inputs();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (rec_valid[e.slot] !== 1'b1 || rec_instIndex[3*e.slot +: 3] !== e.tag ||
          rec_elementMask[MW*e.slot +: MW] !== '0 || occupancy !== 3'd4) begin
        n_errors++;
        $display("FAIL alloc_with_update slot%0d: got v=%b tag=%0d occ=%0d mask_nonzero=%b required v=1 tag=%0d occ=4 mask=0",
                 e.slot, rec_valid[e.slot], rec_instIndex[3*e.slot +: 3], occupancy,
                 |rec_elementMask[MW*e.slot +: MW], e.tag);
      end
    end
  endtask

  // Table holds tags 5,1,2,4 in slots 0..3 on entry.
  task automatic test_duplicate();
    retire_valid = 1; retire_instIndex = 3'd4; tick(); idle_inputs();
    drive_alloc(3'd2, 5'd3); tick(); idle_inputs();
    n_checks++;
    if (rec_valid !== 4'b0111 || dup_error !== 1'b1 || occupancy !== 3'd3 ||
        rec_instIndex[9 +: 3] !== 3'd4) begin
      n_errors++;
      $display("FAIL dup_alloc: got valid=%b dup=%b occ=%0d slot3tag=%0d required 0111/1/3/4",
               rec_valid, dup_error, occupancy, rec_instIndex[9 +: 3]);
    end
    tick();
    n_checks++;
    if (dup_error !== 1'b1) begin
      n_errors++;
      $display("FAIL dup_sticky: got %b required 1", dup_error);
    end
    drive_alloc(3'd1, 5'd4); retire_valid = 1; retire_instIndex = 3'd1;
    tick(); idle_inputs();
    n_checks++;
    if (rec_valid !== 4'b0101 || occupancy !== 3'd2 || dup_error !== 1'b1) begin
      n_errors++;
      $display("FAIL dup_vs_retire: got valid=%b occ=%0d dup=%b required 0101/2/1",
               rec_valid, occupancy, dup_error);
    end
    pulse_reset();
    n_checks++;
    if (dup_error !== 1'b0 || rec_valid !== 4'b0000) begin
      n_errors++;
      $display("FAIL dup_reset: got dup=%b valid=%b required 0/0000", dup_error, rec_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive_alloc(3'd0, 5'd1); tick();
    drive_alloc(3'd1, 5'd2); tick(); idle_inputs();
    update_valid = 1; update_instIndex = 3'd0; update_index = 9'd5; tick(); idle_inputs();
    reset = 1;
    drive_alloc(3'd2, 5'd3);
    update_valid = 1; update_instIndex = 3'd1; update_index = 9'd6;
    retire_valid = 1; retire_instIndex = 3'd1;
    tick(); reset = 0; idle_inputs();
    n_checks++;
    if (rec_valid !== 4'b0000 || occupancy !== 3'd0 || rec_elementMask !== '0 || alloc_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid: got valid=%b occ=%0d masks_nonzero=%b ready=%b required 0000/0/0/1",
               rec_valid, occupancy, |rec_elementMask, alloc_ready);
    end
    retire_valid = 1; retire_instIndex = 3'd0; tick(); idle_inputs();
    n_checks++;
    if (rec_valid !== 4'b0000 || occupancy !== 3'd0) begin
      n_errors++;
      $display("FAIL retire_empty: got valid=%b occ=%0d required 0000/0", rec_valid, occupancy);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_alloc_basic();
    test_fill_and_retire();
    test_update();
    test_simultaneous();
    test_duplicate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chaining_record_table.md
Name: chaining_record_table

Overview:
- Holds the in-flight instruction footprint records (vd/vs1/vs2 registers, instruction index, gather/onlyRead flags, per-element progress mask) that the lane's write-hazard checker evaluates.
- Sits directly upstream of the per-record write checker.
- Allocates a record on instruction issue, sets element-mask bits as elements complete, and frees the record on instruction retire.
- Exposes every slot combinationally from flops each cycle.

Parameters:
- NUM_RECORDS, 4, number of record slots (power of two, 2..8)
- ELEM_MASK_W, 512, element-progress mask width; the index is {vreg[2:0], offset[5:0]}
- INST_IDX_W, 3, instruction index width (wrapping age tag)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- alloc_valid  in  1  issue a new record
- alloc_ready  out  1  a free slot exists
- alloc_vd_valid  in  1  instruction writes vd
- alloc_vd_bits  in  5  destination register group base
- alloc_vs1_valid  in  1  instruction reads vs1
- alloc_vs1_bits  in  5  vs1 base
- alloc_vs2  in  5  vs2 base
- alloc_instIndex  in  INST_IDX_W  instruction tag
- alloc_gather  in  1  gather-type read of vs2
- alloc_gather16  in  1  gather16-type read of vs1
- alloc_onlyRead  in  1  instruction never writes
- update_valid  in  1  mark one element complete
- update_instIndex  in  INST_IDX_W  target record tag
- update_index  in  9  element bit index into the mask
- retire_valid  in  1  instruction finished
- retire_instIndex  in  INST_IDX_W  tag to free
- rec_valid  out  NUM_RECORDS  per-slot valid
- rec_vd_valid, rec_vs1_valid, rec_gather, rec_gather16, rec_onlyRead  out  NUM_RECORDS each  per-slot flags
- rec_vd_bits, rec_vs1_bits, rec_vs2  out  5*NUM_RECORDS each  flattened; slot i is at [5i+4:5i]
- rec_instIndex  out  INST_IDX_W*NUM_RECORDS  flattened tags
- rec_elementMask  out  ELEM_MASK_W*NUM_RECORDS  flattened masks
- occupancy  out  $clog2(NUM_RECORDS+1)  count of valid slots
- dup_error  out  1  sticky protocol-error flag

Behaviour:
- Reset:
  - All rec_valid=0, all masks=0, all fields=0.
  - occupancy=0, dup_error=0, alloc_ready=1.
  - Reset asserted mid-operation discards all records in that cycle; all other inputs are ignored that cycle.
- alloc_ready is 1 when at least one slot is free. It is computed from the current registered state only; a slot freed by a same-cycle retire is not visible until the next cycle.
- Allocation fires when alloc_valid & alloc_ready:
  - Target is the lowest-numbered free slot.
  - All fields are captured and the elementMask is cleared to 0.
  - rec_valid is set at the next edge, so the record is visible one cycle after acceptance.
- Duplicate tag:
  - If alloc fires with a tag equal to any currently valid record's tag, the allocation is dropped (no slot written) and dup_error is set.
  - dup_error clears only on reset.
  - alloc_ready is unaffected.
- Update:
  - update_valid sets bit update_index of the valid record whose tag matches.
  - No match means no effect and no error.
  - Updates are idempotent; bits are never cleared except by allocation.
- Retire:
  - retire_valid clears rec_valid of the matching record.
  - Mask and fields may keep stale values.
  - No match means no effect.
- Simultaneous events in one cycle:
  - Retire and update to the same tag: retire wins.
  - Alloc whose tag equals a same-cycle retire tag is treated as a duplicate, because the check uses pre-edge state.
  - Alloc, update and retire to different slots all take effect.
  - Alloc and update carrying the new tag: the update is ignored, since the record is not yet valid.
- occupancy is a registered count: +1 on accepted alloc, -1 on effective retire, net 0 when both occur in one cycle. It never wraps, by construction (max NUM_RECORDS).
- Full/empty: with all slots valid, alloc_ready=0 and alloc_valid is ignored. Retire on an empty table is a no-op.
- All outputs are driven directly from flops; there is no combinational path from inputs to outputs except alloc_ready, which is also flop-derived.

Decomposition:
- Shared package: the record struct type (vd_valid, vd_bits, vs1_valid, vs1_bits, vs2, instIndex, gather, gather16, onlyRead, elementMask), plus the ELEM_MASK_W and INST_IDX_W constants. The write checker reuses the same package.
- One natural sub-module: chaining_record_slot, a single slot's storage holding its valid flag, fields, mask update and tag-match logic. It is instantiated NUM_RECORDS times with a top-level lowest-free priority encoder.

Test Plan:
- Reset, then alloc tag 3 (vd=8, vd_valid=1) -> next cycle rec_valid=0001, slot0 vd_bits=8, mask=0, occupancy=1.
- Fill 4 slots with tags 0..3 -> alloc_ready=0; a 5th alloc_valid is ignored; retire tag 1 -> next cycle alloc_ready=1 and the next alloc lands in slot 1.
- Updates to tag 2 at indices 0, 63, 511, then 63 again -> slot mask has exactly bits {0,63,511} set; an update to absent tag 5 changes nothing.
- Same cycle: retire tag 0 with update tag 0 index 7, plus alloc tag 4 -> slot0 invalid, tag 4 goes into the lowest pre-edge free slot, occupancy unchanged.
- Alloc tag 2 while tag 2 is valid -> no slot written, dup_error=1 and it stays 1; reset -> dup_error=0, rec_valid=0000.
- Reset asserted in the same cycle as alloc_valid, update_valid and retire_valid -> all records cleared, occupancy=0, no allocation.
